immgen_pipe: RTL and testbench
==============================

Name: immgen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage of the RV32/RV64 core with the interrupt handler.
- Decodes the immediate and immediate class of a 32-bit instruction, sign-extended to XLEN.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, so decode can stall without dropping instructions.
- Supports a pipeline flush for trap/interrupt entry and for branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each instruction

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  discard all buffered entries and any same-cycle input
i_valid  input  1  upstream instruction valid
o_ready  output  1  block can accept an instruction this cycle
i_instr  input  32  instruction word
i_tag  input  TAG_W  sideband tag, passed through unchanged
o_valid  output  1  output entry valid
i_ready  input  1  downstream accepts the output entry
o_imm  output  XLEN  decoded immediate
o_imm_type  output  3  immediate class: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 SHAMT
o_illegal  output  1  opcode not in the supported set
o_instr  output  32  instruction word of the output entry
o_tag  output  TAG_W  tag of the output entry

Behaviour:
- Reset (async assert, sync-released deassert edge): both entries invalid; o_valid=0, o_imm=0, o_imm_type=0, o_illegal=0, o_instr=0, o_tag=0. o_ready=1 while in reset and afterwards whenever the buffer is not full.
- Handshake:
  - Input transfer: i_valid & o_ready & ~i_flush.
  - Output transfer: o_valid & i_ready.
  - o_ready is driven from registered state only (no combinational path from i_ready).
- Latency: an entry transferred in cycle N is presented at the output in cycle N+1 when the buffer was empty. Throughput is 1 per cycle while i_ready=1.
- Skid buffer: 2 entries, strict FIFO order.
  - Count states: EMPTY(0), ONE(1), FULL(2); o_ready = (count!=2).
  - Input only: count+1.
  - Output only: count-1.
  - Both in the same cycle: count unchanged, and the head advances.
- Output fields must hold stable while o_valid=1 and i_ready=0.
- Flush: when i_flush=1, count goes to 0 the next cycle and o_valid=0. Same-cycle input is discarded. Flush has priority over every other event.
- Decode, by opcode (i_instr[6:0]); sx() means sign-extend from bit 31 to XLEN:
  - LUI 0110111 / AUIPC 0010111: sx({instr[31:12],12'b0}), type U.
  - JAL 1101111: sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), type J.
  - B 1100011: sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), type B.
  - JALR 1100111 / LOAD 0000011: sx(instr[31:20]), type I.
  - STORE 0100011: sx({instr[31:25],instr[11:7]}), type S.
  - OP-IMM 0010011:
    - funct3 001/101: zero-extended shamt, type SHAMT. Shamt is instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
    - Otherwise: sx(instr[31:20]), type I.
  - OP-IMM-32 0011011 (XLEN=64 only): as OP-IMM, but shamt is always instr[24:20].
  - SYSTEM 1110011: zero-extended instr[19:15], type Z.
  - OP 0110011 (and OP-32 0111011 when XLEN=64): imm 0, type none, legal.
  - Any other opcode, including OP-IMM-32/OP-32 when XLEN=32: imm 0, type none, o_illegal=1.
- o_illegal is stored per entry and travels with it; it does not affect the handshake.
- Width rule: the top XLEN-32 bits of o_imm replicate bit 31 of the 32-bit result for sign-extended classes, and are 0 for Z and SHAMT.

Test Plan:
- Reset mid-stream with 2 entries buffered → next cycle o_valid=0, o_ready=1, all outputs 0.
- XLEN=32, streaming with i_ready=1: instr 0xFFF00093 (addi -1), then 0x800000EF (jal), then 0x00F00023 (sb) → o_imm 0xFFFFFFFF/I, 0xFFF00000/J, 0x00000000/S, one per cycle, latency 1.
- XLEN=64: 0x03F01093 (slli x1,x0,63) → o_imm 63, type 7. 0x12345037 (lui) → o_imm 0x0000000012345000. 0x80000037 → 0xFFFFFFFF80000000.
- Backpressure: i_ready=0 while sending 3 instructions → 2 accepted, o_ready=0 in the cycle after the second. Output stays stable. Releasing i_ready → entries drain in order, o_ready returns to 1.
- Flush with FULL buffer plus a simultaneous i_valid → next cycle o_valid=0, count 0, the flushed-cycle instruction never appears at the output.
- Opcode 0x0000007F and (XLEN=32) 0x0000001B → o_illegal=1, o_imm=0, type 0. CSR 0x3400D073 → o_imm 1, type 6.

Source files
------------

// File: rtl/immgen_pipe.sv
// Decode-stage immediate generator: decodes a 32-bit instruction's immediate and class,
// then buffers the result in a 2-entry skid FIFO with valid/ready on both sides.
module immgen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_imm_type,
  output logic             o_illegal,
  output logic [31:0]      o_instr,
  output logic [TAG_W-1:0] o_tag
);

  localparam bit IS64 = (XLEN == 64);

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_Z     = 3'd6,
    IMM_SHAMT = 3'd7
  } imm_type_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic            zext;
  imm_type_e       dec_type;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic [5:0]      shamt;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  // RV64 OP-IMM shifts take a 6-bit shamt; the *W forms and RV32 take 5 bits.
  assign shamt  = (IS64 && opcode == OPC_OP_IMM) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

  always_comb begin
    imm32       = '0;
    zext        = 1'b0;
    dec_type    = IMM_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm32    = {i_instr[31:12], 12'b0};
        dec_type = IMM_U;
      end
      OPC_JAL: begin
        imm32    = 32'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
        dec_type = IMM_J;
      end
      OPC_BRANCH: begin
        imm32    = 32'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
        dec_type = IMM_B;
      end
      OPC_JALR, OPC_LOAD: begin
        imm32    = 32'($signed(i_instr[31:20]));
        dec_type = IMM_I;
      end
      OPC_STORE: begin
        imm32    = 32'($signed({i_instr[31:25], i_instr[11:7]}));
        dec_type = IMM_S;
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        if (opcode == OPC_OP_IMM32 && !IS64) begin
          dec_illegal = 1'b1;
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm32    = 32'(shamt);
          zext     = 1'b1;
          dec_type = IMM_SHAMT;
        end else begin
          imm32    = 32'($signed(i_instr[31:20]));
          dec_type = IMM_I;
        end
      end
      OPC_SYSTEM: begin
        imm32    = 32'(i_instr[19:15]);
        zext     = 1'b1;
        dec_type = IMM_Z;
      end
      OPC_OP: ;
      OPC_OP32: dec_illegal = !IS64;
      default:  dec_illegal = 1'b1;
    endcase
  end

  assign dec_imm = zext ? XLEN'(imm32) : XLEN'($signed(imm32));

  // Skid FIFO storage: head points at the oldest entry, count is 0..2.
  logic [XLEN-1:0]  imm_q     [2];
  logic [2:0]       type_q    [2];
  logic             illegal_q [2];
  logic [31:0]      instr_q   [2];
  logic [TAG_W-1:0] tag_q     [2];
  logic [1:0]       count;
  logic             head;
  logic             wr_ptr;
  logic             push;
  logic             pop;

  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = o_valid & i_ready;
  assign wr_ptr  = head ^ count[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= 2'd0;
      head  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i]     <= '0;
        type_q[i]    <= '0;
        illegal_q[i] <= 1'b0;
        instr_q[i]   <= '0;
        tag_q[i]     <= '0;
      end
    end else if (i_flush) begin
      count <= 2'd0;
      head  <= 1'b0;
    end else begin
      if (push) begin
        imm_q[wr_ptr]     <= dec_imm;
        type_q[wr_ptr]    <= dec_type;
        illegal_q[wr_ptr] <= dec_illegal;
        instr_q[wr_ptr]   <= i_instr;
        tag_q[wr_ptr]     <= i_tag;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= 2'(count + 2'd1);
        2'b01:   count <= 2'(count - 2'd1);
        default: count <= count;
      endcase
    end
  end

  assign o_imm      = imm_q[head];
  assign o_imm_type = type_q[head];
  assign o_illegal  = illegal_q[head];
  assign o_instr    = instr_q[head];
  assign o_tag      = tag_q[head];

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: one XLEN=32 and one XLEN=64 instance on a shared clock/reset.
module tb_immgen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // XLEN=32 instance (a_*)
  logic        a_flush, a_vin, a_rdy, a_rin, a_vout, a_ill;
  logic [31:0] a_instr, a_tag, a_imm, a_oinstr, a_otag;
  logic [2:0]  a_type;

  // XLEN=64 instance (b_*)
  logic        b_flush, b_vin, b_rdy, b_rin, b_vout, b_ill;
  logic [31:0] b_instr, b_tag, b_oinstr, b_otag;
  logic [63:0] b_imm;
  logic [2:0]  b_type;

  immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_valid(a_vin), .o_ready(a_rdy),
    .i_instr(a_instr), .i_tag(a_tag), .o_valid(a_vout), .i_ready(a_rin), .o_imm(a_imm),
    .o_imm_type(a_type), .o_illegal(a_ill), .o_instr(a_oinstr), .o_tag(a_otag)
  );

  immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_valid(b_vin), .o_ready(b_rdy),
    .i_instr(b_instr), .i_tag(b_tag), .o_valid(b_vout), .i_ready(b_rin), .o_imm(b_imm),
    .o_imm_type(b_type), .o_illegal(b_ill), .o_instr(b_oinstr), .o_tag(b_otag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [31:0] instr);
    a_vin   = 1'b1;
    a_instr = instr;
    a_tag   = instr ^ 32'hA5A5_0000;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_vin = 1'b0; a_rin = 1'b1; a_instr = '0; a_tag = '0;
    b_flush = 1'b0; b_vin = 1'b0; b_rin = 1'b1; b_instr = '0; b_tag = '0;
    step(); step();

    // Reset state
    chk("rst_valid", 64'(a_vout), 64'd0);
    chk("rst_ready", 64'(a_rdy), 64'd1);
    chk("rst_imm", 64'(a_imm), 64'd0);
    chk("rst_type", 64'(a_type), 64'd0);
    chk("rst_b_imm", b_imm, 64'd0);
    rst_n = 1'b1;
    step();

    // Streaming, i_ready=1, latency 1
    a_send(32'hFFF0_0093);
    step();
    chk("s1_valid", 64'(a_vout), 64'd1);
    chk("s1_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("s1_type", 64'(a_type), 64'd1);
    chk("s1_tag", 64'(a_otag), 64'h5A55_0093);
    a_send(32'h8000_00EF);
    step();
    chk("s2_imm", 64'(a_imm), 64'hFFF0_0000);
    chk("s2_type", 64'(a_type), 64'd5);
    a_send(32'h00F0_0023);
    step();
    chk("s3_imm", 64'(a_imm), 64'd0);
    chk("s3_type", 64'(a_type), 64'd2);
    chk("s3_instr", 64'(a_oinstr), 64'h00F0_0023);
    a_vin = 1'b0;
    step();
    chk("s_drained", 64'(a_vout), 64'd0);

    // Backpressure: three sends with i_ready=0
    a_rin = 1'b0;
    a_send(32'h0010_0093);
    step();
    chk("bp1_ready", 64'(a_rdy), 64'd1);
    chk("bp1_imm", 64'(a_imm), 64'd1);
    a_send(32'h0020_0093);
    step();
    chk("bp2_ready", 64'(a_rdy), 64'd0);
    chk("bp2_imm", 64'(a_imm), 64'd1);
    a_send(32'h0030_0093);
    step();
    chk("bp3_ready", 64'(a_rdy), 64'd0);
    chk("bp3_stable", 64'(a_imm), 64'd1);
    chk("bp3_instr", 64'(a_oinstr), 64'h0010_0093);
    a_rin = 1'b1;
    step();
    chk("bp4_imm", 64'(a_imm), 64'd2);
    chk("bp4_ready", 64'(a_rdy), 64'd1);
    step();
    a_vin = 1'b0;
    chk("bp5_imm", 64'(a_imm), 64'd3);
    step();
    chk("bp6_valid", 64'(a_vout), 64'd0);

    // Flush with FULL buffer and simultaneous input
    a_rin = 1'b0;
    a_send(32'h0040_0093);
    step();
    a_send(32'h0050_0093);
    step();
    chk("fl_full", 64'(a_rdy), 64'd0);
    a_flush = 1'b1;
    a_send(32'h0060_0093);
    step();
    chk("fl_valid", 64'(a_vout), 64'd0);
    chk("fl_ready", 64'(a_rdy), 64'd1);
    a_flush = 1'b0; a_vin = 1'b0; a_rin = 1'b1;
    step();
    chk("fl_nodrop", 64'(a_vout), 64'd0);

    // Illegal opcodes and CSR immediate
    a_send(32'h0000_007F);
    step();
    chk("ill7f_ill", 64'(a_ill), 64'd1);
    chk("ill7f_imm", 64'(a_imm), 64'd0);
    chk("ill7f_type", 64'(a_type), 64'd0);
    a_send(32'h0000_001B);
    step();
    chk("ill1b_ill", 64'(a_ill), 64'd1);
    chk("ill1b_type", 64'(a_type), 64'd0);
    a_send(32'h3400_D073);
    step();
    chk("csr_imm", 64'(a_imm), 64'd1);
    chk("csr_type", 64'(a_type), 64'd6);
    chk("csr_ill", 64'(a_ill), 64'd0);
    a_send(32'h8000_0863);
    step();
    chk("br_imm", 64'(a_imm), 64'hFFFF_F010);
    chk("br_type", 64'(a_type), 64'd3);
    a_send(32'h0000_0033);
    step();
    chk("op_ill", 64'(a_ill), 64'd0);
    chk("op_type", 64'(a_type), 64'd0);
    a_vin = 1'b0;
    step();

    // XLEN=64 decode
    b_vin = 1'b1; b_instr = 32'h03F0_1093; b_tag = 32'h0000_1000;
    step();
    chk("b_slli_imm", b_imm, 64'd63);
    chk("b_slli_type", 64'(b_type), 64'd7);
    b_instr = 32'h1234_5037;
    step();
    chk("b_lui_pos", b_imm, 64'h0000_0000_1234_5000);
    chk("b_lui_type", 64'(b_type), 64'd4);
    b_instr = 32'h8000_0037;
    step();
    chk("b_lui_neg", b_imm, 64'hFFFF_FFFF_8000_0000);
    b_instr = 32'h03F0_109B;
    step();
    chk("b_slliw_imm", b_imm, 64'd31);
    chk("b_slliw_ill", 64'(b_ill), 64'd0);
    b_instr = 32'hFFF0_0093;
    step();
    chk("b_addi_neg", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    b_instr = 32'h0000_003B;
    step();
    chk("b_op32_ill", 64'(b_ill), 64'd0);
    b_vin = 1'b0;
    step();

    // Reset mid-stream with two entries buffered
    a_rin = 1'b0;
    a_send(32'h0070_0093);
    step();
    a_send(32'h0080_0093);
    step();
    a_vin = 1'b0;
    chk("mr_full", 64'(a_rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 64'(a_vout), 64'd0);
    step();
    chk("mr_valid", 64'(a_vout), 64'd0);
    chk("mr_ready", 64'(a_rdy), 64'd1);
    chk("mr_imm", 64'(a_imm), 64'd0);
    chk("mr_instr", 64'(a_oinstr), 64'd0);
    chk("mr_tag", 64'(a_otag), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mr_after", 64'(a_vout), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
